rx_frame_controller: RTL and testbench

- Sequencing controller for the serial receive datapath: input buffer, 10-bit SIPO shift register and processor-side character interface.
- Runs at the sample clock (SAMPLES_PER_BIT samples per serial bit) and detects and qualifies the start bit.
- Strobes the SIPO once per bit at mid-bit, then checks the stop bit.
- Hands the received byte to the processor with a ready/ack handshake, reporting framing and overrun errors.

---
 rtl/rx_frame_controller_if.sv | 23 ++
 rtl/rx_frame_controller.sv | 122 ++++++++++++
 tb/tb_rx_frame_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rx_frame_controller_if.sv
// Character-side signal bundle between the receive controller and its datapath/processor.
// The slave modport is the controller's view; master is the environment driving it.
interface rx_frame_controller_if;
    logic       rx_in;
    logic [9:0] frame_in;
    logic       shift_en;
    logic [7:0] data_out;
    logic       char_ready;
    logic       char_ack;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    modport slave (
        input  rx_in, frame_in, char_ack,
        output shift_en, data_out, char_ready, framing_error, overrun, busy
    );

    modport master (
        output rx_in, frame_in, char_ack,
        input  shift_en, data_out, char_ready, framing_error, overrun, busy
    );
endinterface

// File: rtl/rx_frame_controller.sv
// Serial receive sequencer: qualifies the start bit, strobes the SIPO at mid-bit,
// checks the stop bit and hands each byte to the processor over a ready/ack handshake.
module rx_frame_controller #(
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter int unsigned MID_SAMPLE      = 7,
    parameter int unsigned FRAME_BITS      = 10
) (
    input logic            clk,
    input logic            reset,
    rx_frame_controller_if.slave bus
);

    localparam int unsigned CntW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CntW-1:0] MidLast = CntW'(MID_SAMPLE - 1);
    localparam logic [CntW-1:0] BitLast = CntW'(SAMPLES_PER_BIT - 1);
    localparam logic [3:0]      LastBit = 4'(FRAME_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StStartChk,
        StRecv,
        StCheck,
        StWaitIdle
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] sample_cnt_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      data_out_q;
    logic            char_ready_q;
    logic            framing_error_q;
    logic            overrun_q;
    logic            shift_en;

    // The start bit lands in frame_in[0] and is never looked at again.
    logic unused_start_bit;
    assign unused_start_bit = bus.frame_in[0];

    // Mealy strobe so the SIPO captures rx_in on the same edge the decision is made.
    always_comb begin
        shift_en = 1'b0;
        case (state_q)
            StStartChk: shift_en = (sample_cnt_q == MidLast) && !bus.rx_in;
            StRecv:     shift_en = (sample_cnt_q == BitLast);
            default:    shift_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            sample_cnt_q    <= '0;
            bit_cnt_q       <= '0;
            data_out_q      <= '0;
            char_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            if (char_ready_q && bus.char_ack) begin
                char_ready_q    <= 1'b0;
                framing_error_q <= 1'b0;
                overrun_q       <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (!bus.rx_in) begin
                        state_q      <= StStartChk;
                        sample_cnt_q <= '0;
                    end
                end
                StStartChk: begin
                    if (sample_cnt_q == MidLast) begin
                        sample_cnt_q <= '0;
                        if (!bus.rx_in) begin
                            bit_cnt_q <= 4'd1;
                            state_q   <= StRecv;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        sample_cnt_q <= sample_cnt_q + 1'b1;
                    end
                end
                StRecv: begin
                    if (sample_cnt_q == BitLast) begin
                        sample_cnt_q <= '0;
                        bit_cnt_q    <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LastBit - 4'd1) begin
                            state_q <= StCheck;
                        end
                    end else begin
                        sample_cnt_q <= sample_cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    // Placed after the ack clear so a new delivery overrides a same-cycle ack.
                    data_out_q      <= bus.frame_in[8:1];
                    framing_error_q <= ~bus.frame_in[9];
                    char_ready_q    <= 1'b1;
                    overrun_q       <= char_ready_q & ~bus.char_ack;
                    bit_cnt_q       <= '0;
                    state_q         <= bus.frame_in[9] ? StIdle : StWaitIdle;
                end
                StWaitIdle: begin
                    if (bus.rx_in) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.shift_en      = shift_en;
    assign bus.data_out      = data_out_q;
    assign bus.char_ready    = char_ready_q;
    assign bus.framing_error = framing_error_q;
    assign bus.overrun       = overrun_q;
    assign bus.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench for rx_frame_controller with a behavioural SIPO feeding frame_in.
module tb_rx_frame_controller;

    logic clk;
    logic reset;
    logic [9:0] sipo;
    int total;
    int bad;

    rx_frame_controller_if bus ();

    rx_frame_controller #(
        .SAMPLES_PER_BIT(16),
        .MID_SAMPLE     (7),
        .FRAME_BITS     (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sipo = 10'h3ff;
    always @(posedge clk) if (bus.shift_en) sipo <= {bus.rx_in, sipo[9:1]};
    assign bus.frame_in = sipo;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample-clock cycle: drive at the falling edge, observe 1 time unit later.
    task automatic step(input logic rx, input logic ack, output logic se);
        @(negedge clk);
        bus.rx_in    = rx;
        bus.char_ack = ack;
        #1;
        se = bus.shift_en;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at,
                              input logic rdy152, input logic [7:0] exp_d,
                              input logic exp_fe, input logic exp_ov, input string tag);
        logic [9:0] bits;
        logic se;
        int n;
        logic pos_ok;
        bits   = {stop, d, 1'b0};
        n      = 0;
        pos_ok = 1'b1;
        for (int c = 0; c < 160; c++) begin
            step(bits[c / 16], (c == ack_at), se);
            if (se) begin
                n++;
                if ((c % 16) != 7) pos_ok = 1'b0;
            end
            if (c == 152) begin
                chk({tag, " busy@152"}, bus.busy, 1'b1);
                chk({tag, " ready@152"}, bus.char_ready, rdy152);
            end
            if (c == 153) begin
                chk({tag, " ready@153"}, bus.char_ready, 1'b1);
                chk({tag, " data"}, bus.data_out, exp_d);
                chk({tag, " framing"}, bus.framing_error, exp_fe);
                chk({tag, " overrun"}, bus.overrun, exp_ov);
            end
        end
        chk({tag, " pulses"}, n, 10);
        chk({tag, " pulse_pos"}, pos_ok, 1'b1);
    endtask

    task automatic ack_and_check(input string tag);
        logic se;
        step(1'b1, 1'b1, se);
        step(1'b1, 1'b0, se);
        chk({tag, " ack ready"}, bus.char_ready, 1'b0);
        chk({tag, " ack framing"}, bus.framing_error, 1'b0);
        chk({tag, " ack overrun"}, bus.overrun, 1'b0);
    endtask

    initial begin
        logic se;
        int n;
        int busy_n;
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        bus.rx_in    = 1'b1;
        bus.char_ack = 1'b0;

        // Reset state
        repeat (3) step(1'b1, 1'b0, se);
        chk("rst shift_en", se, 1'b0);
        chk("rst data", bus.data_out, 8'h00);
        chk("rst ready", bus.char_ready, 1'b0);
        chk("rst framing", bus.framing_error, 1'b0);
        chk("rst overrun", bus.overrun, 1'b0);
        chk("rst busy", bus.busy, 1'b0);
        reset = 1'b1;
        repeat (4) step(1'b1, 1'b0, se);

        // Clean frame 0x55
        send_frame(8'h55, 1'b1, -1, 1'b0, 8'h55, 1'b0, 1'b0, "f55");
        step(1'b1, 1'b0, se);
        chk("f55 idle after", bus.busy, 1'b0);
        ack_and_check("f55");

        // Start glitch: low 3 cycles then high
        n      = 0;
        busy_n = 0;
        for (int c = 0; c < 16; c++) begin
            step((c < 3) ? 1'b0 : 1'b1, 1'b0, se);
            if (se) n++;
            if (bus.busy) busy_n++;
        end
        chk("glitch shifts", n, 0);
        chk("glitch busy_len_ok", (busy_n > 0) && (busy_n <= 8), 1'b1);
        chk("glitch busy end", bus.busy, 1'b0);
        chk("glitch ready", bus.char_ready, 1'b0);

        // Bad stop bit, then line held low
        send_frame(8'hA3, 1'b0, -1, 1'b0, 8'hA3, 1'b1, 1'b0, "fA3");
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 1'b0, se);
            if (se) n++;
        end
        chk("break shifts", n, 0);
        chk("break busy", bus.busy, 1'b1);
        chk("break framing", bus.framing_error, 1'b1);
        step(1'b1, 1'b0, se);
        step(1'b1, 1'b0, se);
        chk("break released idle", bus.busy, 1'b0);
        ack_and_check("fA3");

        // Two frames, no ack in between
        send_frame(8'h12, 1'b1, -1, 1'b0, 8'h12, 1'b0, 1'b0, "f12");
        send_frame(8'h34, 1'b1, -1, 1'b1, 8'h34, 1'b0, 1'b1, "f34ov");
        ack_and_check("f34ov");

        // Ack lands in the CHECK cycle of the second frame
        send_frame(8'h12, 1'b1, -1, 1'b0, 8'h12, 1'b0, 1'b0, "f12b");
        send_frame(8'h34, 1'b1, 152, 1'b1, 8'h34, 1'b0, 1'b0, "f34ack");
        ack_and_check("f34ack");

        // Reset mid-frame at cycle 80
        for (int c = 0; c < 80; c++) step((c < 16) ? 1'b0 : 1'b1, 1'b0, se);
        reset = 1'b0;
        repeat (5) step(1'b1, 1'b0, se);
        chk("abort busy", bus.busy, 1'b0);
        chk("abort shift_en", se, 1'b0);
        reset = 1'b1;
        repeat (200) step(1'b1, 1'b0, se);
        chk("abort no delivery", bus.char_ready, 1'b0);
        chk("abort data", bus.data_out, 8'h00);
        send_frame(8'h0F, 1'b1, -1, 1'b0, 8'h0F, 1'b0, 1'b0, "f0F");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
